data_mem_loader: RTL

// Bulk loader sitting directly upstream of the data memory write port. Accepts a byte

---
 rtl/data_mem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/data_mem_loader.sv
// Streams bytes into little-endian 32-bit words and writes them to consecutive aligned
// data-memory addresses, passing the CPU's memory signals through whenever it is not loading.
module data_mem_loader #(
  parameter int unsigned MEM_BYTES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_words,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memwrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [33:0] MEM_LIMIT = 34'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [15:0] words_left_q, words_left_d;
  logic        err_q, err_d;

  // End address is formed one bit wider than needed so a base near 2^32 cannot wrap past the limit.
  logic [33:0] load_end;
  logic        bad_start;

  assign load_end  = {2'b00, base_addr} + {16'b0, num_words, 2'b00};
  assign bad_start = (base_addr[1:0] != 2'b00) || (load_end > MEM_LIMIT);
  assign err       = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      cur_addr_q   <= 32'd0;
      words_left_q <= 16'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      err_q        <= err_d;
    end
  end

  // NOTE: every output and next-state value gets a default first so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    err_d        = err_q;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_memwrite = cpu_memwrite;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_start) begin
            err_d = 1'b1;
          end else if (num_words == 16'd0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            err_d        = 1'b0;
            cur_addr_d   = base_addr;
            words_left_d = num_words;
            byte_cnt_d   = 2'd0;
            state_d      = FILL;
          end
        end
      end
      FILL: begin
        busy         = 1'b1;
        in_ready     = 1'b1;
        mem_addr     = cur_addr_q;
        mem_wdata    = word_q;
        mem_memwrite = 1'b0;
        if (in_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        busy         = 1'b1;
        mem_addr     = cur_addr_q;
        mem_wdata    = word_q;
        mem_memwrite = 1'b1;
        cur_addr_d   = cur_addr_q + 32'd4;
        words_left_d = words_left_q - 16'd1;
        byte_cnt_d   = 2'd0;
        state_d      = (words_left_q == 16'd1) ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Memory must never see a write while reset is held, whatever the CPU drives.
    if (!rst) mem_memwrite = 1'b0;
  end

endmodule
